load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Core-side initiator for the data memory / memory-mapped IO port. Accepts one load or store
//   per handshake from the RV32I execute stage and drives the memory word address, byte enables,
//   replicated store data and write enable. For loads it waits out the memory read latency, then
//   aligns and sign- or zero-extends the returned word.
//   Flags misaligned accesses and illegal funct3 codes without touching memory.
// PARAMETERS
//   MEM_READ_LATENCY  1   cycles from ISSUE cycle until mem_q is valid (>=1)
//   ADDR_WIDTH        12  width of mem_address (word address; bit 11 = IO write, bit 10 = IO read)
// PORTS
//   clock           in   1   single clock, rising edge
//   reset           in   1   asynchronous, active-low reset
//   req_valid       in   1   request present
//   req_ready       out  1   unit can accept a request (IDLE only)
//   req_write       in   1   1 = store, 0 = load
//   req_funct3      in   3   RV32I funct3 of the load/store
//   req_address     in   32  byte address
//   req_wdata       in   32  store data (low bits used for SB/SH)
//   rsp_valid       out  1   one-cycle response pulse
//   rsp_rdata       out  32  extended load data (0 for stores and errors)
//   rsp_error       out  1   misaligned address or illegal funct3 (valid with rsp_valid)
//   mem_address     out  12  word address = req_address[13:2]
//   mem_byteena     out  4   byte enables
//   mem_data        out  32  write data, lane-replicated
//   mem_wren        out  1   write strobe
//   mem_q           in   32  read data from memory/IO mux
// BEHAVIOUR
// - Reset (async, reset low): state IDLE; all outputs 0 except req_ready=1; wait counter 0.
//   Asserting reset mid-access: mem_wren drops immediately; no rsp_valid for the aborted access.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; ready=1 only in IDLE; accept = req_valid & req_ready.
//   Request fields are captured into internal registers at the accept edge.
// - Error check at accept:
//   - Illegal funct3: loads allow 000,001,010,100,101; stores allow 000,001,010.
//   - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
//   - On error go IDLE -> RESP directly: rsp_error=1, rdata=0, memory outputs unchanged, mem_wren=0.
// - ISSUE (1 cycle): mem_address/byteena/data registered from captured request.
//   - mem_wren=1 only here and only for stores.
//   - Byteena: SB = 1<<addr[1:0]; SH = addr[1] ? 1100 : 0011; SW = 1111; loads use the same masks.
//   - mem_data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
//   - Next state: store -> RESP; load -> WAIT.
// - Memory output hold: mem_address/byteena hold their values through WAIT and RESP.
//   mem_data holds through RESP. All memory outputs change only in ISSUE.
// - WAIT: counter counts 1..MEM_READ_LATENCY. In the last count cycle mem_q is sampled,
//   lane-selected by addr[1:0], and extended:
//   - LB/LBU: byte; LH/LHU: halfword (addr[1] selects the upper half); LW: full word.
//   - LB/LH sign-extend, LBU/LHU zero-extend.
//   Then -> RESP.
// - RESP (1 cycle): rsp_valid=1 with rsp_rdata/rsp_error. No response backpressure. -> IDLE.
// - rsp_rdata and rsp_error hold their last value after RESP until the next RESP.
// - Latency from the accept edge: error = 1 cycle; store = 2 cycles; load = 2+MEM_READ_LATENCY cycles.
// - req_address[31:14] is ignored (address space wraps modulo 16 KiB).
// - req_* changes while the unit is busy are ignored.
// TESTING
// - Byte store, lane 1: SB addr 0x5, wdata 0x1234_56AB.
//   -> ISSUE: mem_address=1, byteena=0010, mem_data=0xABAB_ABAB; mem_wren high exactly 1 cycle;
//      rsp_valid 2 cycles after accept; rdata=0, error=0.
// - Signed vs unsigned byte load: LB addr 0x3, then LBU addr 0x3, mem_q=0x80FF_FF00 both times.
//   -> rsp_rdata=0xFFFF_FF80 for LB, then 0x0000_0080 for LBU; rsp_valid 3 cycles after accept.
// - Misaligned halfword load: LH addr 0x1.
//   -> rsp_valid+rsp_error 1 cycle after accept; mem_wren never high; rdata=0.
// - Illegal store funct3: SW-type request with funct3=100.
//   -> rsp_error=1 1 cycle after accept; mem_wren never high.
// - IO write then IO read: SW addr 0x2000 wdata 0x3FF -> mem_address=0x800, byteena=1111, wren pulse.
//   LW addr 0x1000 with mem_q=0x155 -> mem_address=0x400, rsp_rdata=0x155.
// - Back-to-back requests with req_valid held high: req_ready=0 from accept until return to IDLE;
//   next accept comes the cycle after RESP.
//   Reset pulse during WAIT -> no rsp_valid, req_ready=1 immediately after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Core-side initiator for the data memory / memory-mapped IO port. It takes one
//   RV32I load or store per handshake and walks it through IDLE -> ISSUE -> WAIT -> RESP.
//   ISSUE drives the memory word address, byte enables, lane-replicated store data and
//   (stores only) a one-cycle write strobe. Loads wait out the memory read latency, then
//   lane-select and sign/zero-extend mem_q. Misaligned accesses and illegal funct3 codes
//   skip memory entirely and answer with rsp_error one cycle after accept.
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_write, req_funct3, req_address, req_wdata   request fields, captured at accept
//   rsp_valid, rsp_rdata, rsp_error                 one-cycle response, data/error held after
//   mem_address, mem_byteena, mem_data, mem_wren    memory command, changed only on entry to ISSUE
//   mem_q                                           memory / IO read data
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int ADDR_WIDTH       = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteena,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q
);

  localparam int CNT_W = (MEM_READ_LATENCY < 2) ? 1 : $clog2(MEM_READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             cap_write;
  logic [2:0]       cap_funct3;
  logic [1:0]       cap_lane;
  logic             accept;
  logic             accept_error;
  logic             unused_addr_bits;

  // Address bits above the 16 KiB window are deliberately dropped (address wraps).
  assign unused_addr_bits = ^req_address[31:ADDR_WIDTH+2];

  // Illegal funct3 for the direction, or an address not aligned to the access size.
  function automatic logic req_is_error(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    case (f3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = wr;
      default:                illegal = 1'b1;
    endcase
    case (f3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

  // Byte-enable mask for the access size and lane.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data replicated into every lane so the byte enables alone pick the target.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Lane select and sign/zero extension of the returned word.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] q);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = q[7:0];
      2'b01:   b = q[15:8];
      2'b10:   b = q[23:16];
      2'b11:   b = q[31:24];
      default: b = q[7:0];
    endcase
    h = lane[1] ? q[31:16] : q[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = q;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign accept       = req_valid & req_ready;
  assign accept_error = req_is_error(req_write, req_funct3, req_address[1:0]);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (accept_error) begin
            state_next = RESP;
          end else begin
            state_next = ISSUE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (cap_write) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == CNT_LAST) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, memory command, wait counter and response registers.
  // Memory outputs are loaded at the accept edge so they are valid during ISSUE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_error   <= 1'b0;
      mem_address <= '0;
      mem_byteena <= 4'd0;
      mem_data    <= 32'd0;
      mem_wren    <= 1'b0;
      wait_cnt    <= '0;
      cap_write   <= 1'b0;
      cap_funct3  <= 3'd0;
      cap_lane    <= 2'd0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      mem_wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
            cap_lane   <= req_address[1:0];
            if (accept_error) begin
              rsp_error <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              mem_address <= req_address[ADDR_WIDTH+1:2];
              mem_byteena <= byte_mask(req_funct3[1:0], req_address[1:0]);
              mem_data    <= lane_data(req_funct3[1:0], req_wdata);
              mem_wren    <= req_write;
            end
          end
        end
        ISSUE: begin
          if (cap_write) begin
            rsp_error <= 1'b0;
            rsp_rdata <= 32'd0;
          end else begin
            wait_cnt <= CNT_ONE;
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_LAST) begin
            rsp_error <= 1'b0;
            rsp_rdata <= load_extend(cap_funct3, cap_lane, mem_q);
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        RESP: begin
          wait_cnt <= '0;
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed, table-driven bench for load_store_unit: a table of load/store records with
//   hand-computed memory command, latency and response, followed by hand-written
//   sequences for back-to-back requests and reset in the middle of an access.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  load_store_unit dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .mem_address (mem_address),
    .mem_byteena (mem_byteena),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memq;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [11:0] maddr;
    logic [3:0]  be;
    logic [31:0] mdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  int n_vec;
  int n_fail;
  int n_chk;
  logic [11:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   wren_cnt;
    logic got;
    logic [11:0] ea;
    logic [3:0]  eb;
    logic [31:0] ed;
    ea = v.err ? last_addr : v.maddr;
    eb = v.err ? last_be   : v.be;
    ed = v.err ? last_data : v.mdata;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_write   = v.wr;
    req_funct3  = v.f3;
    req_address = v.addr;
    req_wdata   = v.wdata;
    mem_q       = v.memq;
    req_valid   = 1'b1;
    tick();
    // Busy-time changes on the request port must have no effect.
    req_valid   = 1'b0;
    req_write   = ~v.wr;
    req_funct3  = 3'b111;
    req_address = 32'hFFFF_FFFF;
    req_wdata   = 32'h5A5A_5A5A;
    cyc = 1;
    wren_cnt = 0;
    got = 1'b0;
    while (cyc <= 20 && !got) begin
      if (cyc == 1) begin
        chk("issue_addr", {20'd0, mem_address}, {20'd0, ea});
        chk("issue_be",   {28'd0, mem_byteena}, {28'd0, eb});
        chk("issue_data", mem_data, ed);
      end
      if (mem_wren) wren_cnt++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        chk("ready_busy", {31'd0, req_ready}, 32'd0);
        tick();
        cyc++;
      end
    end
    chk("latency",   cyc, v.lat);
    chk("rsp_error", {31'd0, rsp_error}, {31'd0, v.err});
    chk("rsp_rdata", rsp_rdata, v.rdata);
    chk("wren_cnt",  wren_cnt, (v.wr && !v.err) ? 1 : 0);
    chk("hold_addr", {20'd0, mem_address}, {20'd0, ea});
    chk("hold_be",   {28'd0, mem_byteena}, {28'd0, eb});
    chk("hold_data", mem_data, ed);
    tick();
    chk("rsp_pulse",  {31'd0, rsp_valid}, 32'd0);
    chk("ready_back", {31'd0, req_ready}, 32'd1);
    chk("rdata_hold", rsp_rdata, v.rdata);
    chk("error_hold", {31'd0, rsp_error}, {31'd0, v.err});
    if (!v.err) begin
      last_addr = v.maddr;
      last_be   = v.be;
      last_data = v.mdata;
    end
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_rdy [6];
    logic exp_rsp [6];
    logic exp_wr  [6];
    n_vec = 0; n_fail = 0; n_chk = 0;
    last_addr = 12'd0; last_be = 4'd0; last_data = 32'd0;

    //          wr    f3      addr           wdata          memq           lat err  rdata          maddr    be       mdata
    vecs[0]  = '{1'b1, 3'b000, 32'h0000_0005, 32'h1234_56AB, 32'h0,         2, 1'b0, 32'h0,         12'h001, 4'b0010, 32'hABAB_ABAB};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0003, 32'h0,         32'h80FF_FF00, 3, 1'b0, 32'hFFFF_FF80, 12'h000, 4'b1000, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0003, 32'h0,         32'h80FF_FF00, 3, 1'b0, 32'h0000_0080, 12'h000, 4'b1000, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,         32'hFFFF_FFFF, 1, 1'b1, 32'h0,         12'h000, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 3'b100, 32'h0000_0010, 32'hCAFE_0001, 32'h0,         1, 1'b1, 32'h0,         12'h000, 4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 3'b010, 32'h0000_2000, 32'h0000_03FF, 32'h0,         2, 1'b0, 32'h0,         12'h800, 4'b1111, 32'h0000_03FF};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'h0000_0155, 3, 1'b0, 32'h0000_0155, 12'h400, 4'b1111, 32'h0};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0006, 32'hAAAA_BEEF, 32'h0,         2, 1'b0, 32'h0,         12'h001, 4'b1100, 32'hBEEF_BEEF};
    vecs[8]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 3, 1'b0, 32'hFFFF_8001, 12'h000, 4'b1100, 32'h0};
    vecs[9]  = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,         32'h8001_F00D, 3, 1'b0, 32'h0000_F00D, 12'h000, 4'b0011, 32'h0};
    vecs[10] = '{1'b0, 3'b000, 32'h0000_0001, 32'h0,         32'h0000_7F00, 3, 1'b0, 32'h0000_007F, 12'h000, 4'b0010, 32'h0};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,         32'h1111_1111, 1, 1'b1, 32'h0,         12'h000, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h1111_1111, 1, 1'b1, 32'h0,         12'h000, 4'b0000, 32'h0};
    vecs[13] = '{1'b1, 3'b010, 32'hFFFF_C004, 32'hDEAD_BEEF, 32'h0,         2, 1'b0, 32'h0,         12'h001, 4'b1111, 32'hDEAD_BEEF};
    vecs[14] = '{1'b1, 3'b010, 32'h0000_0001, 32'h0BAD_0BAD, 32'h0,         1, 1'b1, 32'h0,         12'h000, 4'b0000, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h0000_3FFC, 32'h0,         32'h1234_5678, 3, 1'b0, 32'h1234_5678, 12'hFFF, 4'b1111, 32'h0};

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_wdata = 32'd0; mem_q = 32'd0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp",   {31'd0, rsp_valid}, 32'd0);
    chk("rst_wren",  {31'd0, mem_wren},  32'd0);
    chk("rst_addr",  {20'd0, mem_address}, 32'd0);
    chk("rst_be",    {28'd0, mem_byteena}, 32'd0);
    chk("rst_data",  mem_data,  32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'd0, rsp_error}, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Back-to-back stores with req_valid held high.
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_rsp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_wr  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    chk("b2b_ready0", {31'd0, req_ready}, 32'd1);
    req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h0000_0008;
    req_wdata = 32'h0000_0001; req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("b2b_ready", {31'd0, req_ready}, {31'd0, exp_rdy[k]});
      chk("b2b_rsp",   {31'd0, rsp_valid}, {31'd0, exp_rsp[k]});
      chk("b2b_wren",  {31'd0, mem_wren},  {31'd0, exp_wr[k]});
    end
    req_valid = 1'b0;
    tick();
    n_vec++;

    // Reset while a load sits in WAIT: no response, ready straight after release.
    req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0000_0040;
    mem_q = 32'hCAFE_F00D; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_rsp",   {31'd0, rsp_valid}, 32'd0);
    chk("rstw_addr",  {20'd0, mem_address}, 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rstw_norsp", {31'd0, rsp_valid}, 32'd0);
      chk("rstw_rdy",   {31'd0, req_ready}, 32'd1);
      tick();
    end
    n_vec++;

    // Reset during a store's ISSUE cycle drops the write strobe at once.
    req_write = 1'b1; req_funct3 = 3'b010; req_address = 32'h0000_0004;
    req_wdata = 32'h0000_0077; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rsts_wren_on", {31'd0, mem_wren}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rsts_wren_off", {31'd0, mem_wren}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rsts_norsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("rsts_norsp2", {31'd0, rsp_valid}, 32'd0);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
